// File: rtl/int_pkg.sv
// Shared definitions for the interrupt vectoring sequencer.
//   - source index constants (bit positions in the request vector)
//   - sequencer state encoding
//   - vector stride / default base address
//   - helpers: lowest set request, per-source clear strobe decode
package int_pkg;

    localparam int NUM_SRC = 5;

    localparam logic [2:0] SRC_INT0 = 3'd0;
    localparam logic [2:0] SRC_TF0  = 3'd1;
    localparam logic [2:0] SRC_INT1 = 3'd2;
    localparam logic [2:0] SRC_TF1  = 3'd3;
    localparam logic [2:0] SRC_SER  = 3'd4;

    localparam logic [15:0] VEC_STRIDE       = 16'd8;
    localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0003;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Lowest set bit wins (bit0 = highest natural priority).
    function automatic logic [2:0] lowest_src(input logic [NUM_SRC-1:0] v);
        logic [2:0] idx;
        idx = SRC_SER;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Serial flags (RI/TI) are cleared by software, so no strobe for SRC_SER.
    function automatic logic [NUM_SRC-1:0] src_clear(input logic [2:0] idx);
        logic [NUM_SRC-1:0] clr;
        clr = '0;
        case (idx)
            SRC_INT0: clr[SRC_INT0] = 1'b1;
            SRC_TF0:  clr[SRC_TF0]  = 1'b1;
            SRC_INT1: clr[SRC_INT1] = 1'b1;
            SRC_TF1:  clr[SRC_TF1]  = 1'b1;
            default:  clr = '0;
        endcase
        return clr;
    endfunction

endpackage

// File: rtl/int_vector_seq_arb.sv
// int_prio_arb: combinational two-level priority arbiter.
// Ports:
//   req       in  5  enabled request vector
//   ip        in  5  per-source priority level (1 = high)
//   elig_hi   in  1  high-level sources may win
//   elig_lo   in  1  low-level sources may win
//   win_valid out 1  a winner exists
//   win_idx   out 3  winning source index
//   win_level out 1  level of the winner (1 = high)
module int_prio_arb
    import int_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] ip,
    input  logic               elig_hi,
    input  logic               elig_lo,
    output logic               win_valid,
    output logic [2:0]         win_idx,
    output logic               win_level
);

    logic [NUM_SRC-1:0] hi_req;
    logic [NUM_SRC-1:0] lo_req;

    always_comb begin
        hi_req    = req & ip  & {NUM_SRC{elig_hi}};
        lo_req    = req & ~ip & {NUM_SRC{elig_lo}};
        win_valid = (|hi_req) | (|lo_req);
        win_level = |hi_req;
        win_idx   = (|hi_req) ? lowest_src(hi_req) : lowest_src(lo_req);
    end

endmodule

// File: rtl/int_vector_seq.sv
// Interrupt vectoring sequencer for the 8051 core.
// Arbitrates enabled requests at instruction boundaries, presents the
// winning vector via irq_req/irq_ack, tracks two-level in-service state
// until RETI and strobes hardware-cleared flags on vectoring.
// Build option: INT_NESTING_EN enables the high priority level (IP) and
// nesting; without it every source is low level and in_service[1] is 0.
// Ports:
//   clk            in   1   core clock
//   rst_n          in   1   asynchronous active-low reset
//   interupt       in   5   enabled requests {SER, TF1, INT1, TF0, INT0}
//   IP             in   5   priority bits (1 = high)
//   instr_boundary in   1   CPU may be interrupted this cycle
//   reti           in   1   CPU executed RETI
//   irq_ack        in   1   CPU accepted the vector
//   irq_req        out  1   vector request
//   irq_vec        out  16  vector address, valid with irq_req
//   clr_src        out  5   one-cycle flag clear strobes
//   in_service     out  2   {high active, low active}
//
// state   | meaning
// ST_IDLE | waiting for an instruction boundary with an eligible request
// ST_REQ  | winner latched, irq_req held until irq_ack
module int_vector_seq
    import int_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] interupt,
    input  logic [NUM_SRC-1:0] IP,
    input  logic               instr_boundary,
    input  logic               reti,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [15:0]        irq_vec,
    output logic [NUM_SRC-1:0] clr_src,
    output logic [1:0]         in_service
);

    state_t             state_q, state_d;
    logic [2:0]         idx_q;
    logic               level_q;
    logic [15:0]        vec_q;
    logic [1:0]         is_q, is_d;
    logic               holdoff_q;
    logic [NUM_SRC-1:0] clr_q, clr_d;
    logic [NUM_SRC-1:0] ip_eff;
    logic               elig_hi, elig_lo;
    logic               win_valid, win_level;
    logic [2:0]         win_idx;
    logic               arb_go, ack_go;

`ifdef INT_NESTING_EN
    assign ip_eff  = IP;
    assign elig_hi = ~is_q[1] & ~holdoff_q;
`else
    logic unused_ip;
    assign unused_ip = ^IP;
    assign ip_eff    = '0;
    assign elig_hi   = 1'b0;
`endif
    assign elig_lo = (is_q == 2'b00) & ~holdoff_q;

    int_prio_arb u_arb (
        .req       (interupt),
        .ip        (ip_eff),
        .elig_hi   (elig_hi),
        .elig_lo   (elig_lo),
        .win_valid (win_valid),
        .win_idx   (win_idx),
        .win_level (win_level)
    );

    always_comb begin
        state_d = state_q;
        arb_go  = 1'b0;
        ack_go  = 1'b0;
        is_d    = is_q;
        clr_d   = '0;
        case (state_q)
            ST_IDLE: begin
                // A boundary coinciding with RETI is never arbitrated.
                if (instr_boundary && !reti && win_valid) begin
                    arb_go  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    ack_go  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // RETI retires the pre-existing level before a simultaneous ack sets the new one.
        if (reti) begin
            if (is_d[1]) is_d[1] = 1'b0;
            else         is_d[0] = 1'b0;
        end
        if (ack_go) begin
            is_d[level_q] = 1'b1;
            clr_d         = src_clear(idx_q);
        end
`ifndef INT_NESTING_EN
        is_d[1] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            level_q   <= 1'b0;
            vec_q     <= '0;
            is_q      <= '0;
            holdoff_q <= 1'b0;
            clr_q     <= '0;
        end else begin
            if (arb_go) begin
                idx_q   <= win_idx;
                level_q <= win_level;
                vec_q   <= VEC_BASE + VEC_STRIDE * {13'b0, win_idx};
            end
            is_q  <= is_d;
            clr_q <= clr_d;
            // The first IDLE boundary after RETI only drops holdoff, so one instruction runs.
            if (reti)
                holdoff_q <= 1'b1;
            else if (instr_boundary && state_q == ST_IDLE)
                holdoff_q <= 1'b0;
        end
    end

    // Decoded from the state register so reset drops the request immediately.
    assign irq_req    = (state_q == ST_REQ);
    assign irq_vec    = vec_q;
    assign clr_src    = clr_q;
    assign in_service = is_q;

endmodule

// File: doc/int_vector_seq.md
# int_vector_seq

Interrupt vectoring sequencer for the 8051 core, directly downstream of `IntControl`. It takes the enabled, masked request vector `interupt[4:0]` and the IP priority bits, and arbitrates at CPU instruction boundaries. It hands the winning vector address to the CPU through a req/ack handshake and tracks the two-level in-service state until RETI. It also pulses per-source clear strobes so hardware-cleared flags (IE0, TF0, IE1, TF1) are reset on vectoring.

## Interface
Parameters:
- `VEC_BASE`, default 16'h0003: address of source 0; source i vectors to `VEC_BASE + 8*i`.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `interupt`  in  5  enabled requests from `IntControl`:
  - bit0 INT0, bit1 TF0, bit2 INT1, bit3 TF1, bit4 serial (RI|TI).
- `IP`  in  5  priority bits `IP[4:0]`; 1 = high level.
- `instr_boundary`  in  1  one-cycle pulse; the CPU is at an instruction end and may be interrupted.
- `reti`  in  1  one-cycle pulse; the CPU executed RETI.
- `irq_ack`  in  1  the CPU accepted the vector and started the hardware LCALL.
- `irq_req`  out  1  vector request to the CPU.
- `irq_vec`  out  16  vector address; valid while `irq_req`=1.
- `clr_src`  out  5  one-cycle clear strobes to the flag logic.
- `in_service`  out  2  {high level active, low level active}.

## Operation
- States: IDLE, REQ.
- Eligibility, evaluated in IDLE at `instr_boundary`=1:
  - a high-level source is eligible if `in_service[1]`=0;
  - a low-level source is eligible if `in_service`==0;
  - no source is eligible while `holdoff`=1.
- Winner: any eligible high-level source beats any low-level source. Within a level, the lowest index wins (bit0 highest).
- IDLE→REQ when a winner exists at the boundary:
  - latch the winner index;
  - `irq_vec` = `VEC_BASE` + 8*idx;
  - latch its level.
- The latched winner is frozen in REQ. A request deasserting afterwards does not cancel it.
- REQ: hold `irq_req`=1 and `irq_vec` stable until `irq_ack`=1.
- On the ack cycle:
  - set the in-service bit of the latched level;
  - pulse `clr_src[idx]` if idx∈{0,1,2,3}; never pulse for idx 4 (the serial flags are cleared by software);
  - next state IDLE.
- `reti`: clear `in_service[1]` if it is set, else clear `in_service[0]`. If neither is set, no in-service change. In all cases set `holdoff`.
- `holdoff` clears at the next `instr_boundary`. That boundary is not arbitrated, so at least one instruction runs after RETI.
- `instr_boundary` in REQ is ignored. `irq_ack` in IDLE is ignored.

## Timing
- Reset values: `irq_req`=0, `irq_vec`=0, `clr_src`=0, `in_service`=0, `holdoff`=0, state IDLE.
- Latency: a boundary in cycle N with a winner gives `irq_req`=1 and a valid `irq_vec` in cycle N+1.
- `irq_ack` sampled in cycle M:
  - `clr_src` is high in cycle M+1 only;
  - `in_service` updates in M+1;
  - `irq_req`=0 in M+1.
- The earliest re-arbitration is the next boundary after returning to IDLE.
- `reti` and `irq_ack` in the same cycle: apply the RETI clear to the pre-existing state first, then set the new level. `holdoff` is also set.
- `reti` and `instr_boundary` in the same cycle: no arbitration; `holdoff` is set.
- Asynchronous reset mid-REQ: `irq_req` drops immediately and all state clears. No `clr_src` pulse.

## Configuration
- `INT_NESTING_EN` defined:
  - two-level behaviour as above;
  - a high-level source preempts a low-level service.
- `INT_NESTING_EN` undefined:
  - `IP` is ignored and every source is treated as low level;
  - `in_service[1]` is tied 0;
  - no request is eligible while `in_service[0]`=1;
  - `reti` clears `in_service[0]`.

## Structure
- Package `int_pkg` holds:
  - source index constants (SRC_INT0..SRC_SER);
  - the state encoding (IDLE, REQ);
  - the vector stride 8;
  - the `VEC_BASE` default.
- Sub-module `int_prio_arb`: combinational. Inputs are the request vector, IP and the eligibility masks; outputs are winner valid, index (3 bits) and level. It is instantiated once.

## Test plan
- `interupt`=5'b00110, `IP`=0, boundary → the next cycle shows `irq_req`=1 and `irq_vec`=16'h000B. After ack, `clr_src`=5'b00010 for one cycle and `in_service`=2'b01.
- `interupt`=5'b00011, `IP`=5'b00010, boundary → `irq_vec`=16'h000B (high-level TF0 beats INT0).
- Low-level INT0 in service, then `interupt`=5'b10000 with `IP[4]`=1 → vector 16'h0023, `clr_src`=0 on ack, `in_service`=2'b11. With the macro undefined, no `irq_req`.
- `reti` with `in_service`=2'b11 → 2'b01. The immediately following boundary with a pending request is ignored; the second boundary produces `irq_req`.
- `irq_ack` held off for 10 cycles while `interupt` drops to 0 → `irq_vec` stays frozen and `irq_req` stays 1 until ack.
- `rst_n` driven low during REQ → `irq_req`=0 asynchronously, `in_service`=0, and no `clr_src` pulse after release.
